// File: rtl/dpsk_decode.sv
// DPSK receiver: correlates each symbol against a phase-0 reference carrier,
// slices the sign to an absolute code, then differentially decodes it.
module dpsk_decode #(
    parameter int SPS    = 16,
    parameter int THRESH = 1024
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           sample_en,
    input  logic                           sym_sync,
    input  logic [7:0]                     rx_sample,
    input  logic [7:0]                     ref_sample,
    output logic                           m_code_out,
    output logic                           abs_code_out,
    output logic                           code_valid,
    output logic                           erasure,
    output logic signed [16+$clog2(SPS)-1:0] sym_metric
);
    localparam int ACC_W = 16 + $clog2(SPS);
    localparam int CNT_W = $clog2(SPS);

    logic signed [7:0]       rs;
    logic signed [7:0]       cs;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic        [ACC_W:0]   sum_ext;
    logic        [ACC_W:0]   mag;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    d_prev_q, d_prev_d;
    logic                    m_code_q, m_code_d;
    logic                    abs_code_q, abs_code_d;
    logic                    valid_q, valid_d;
    logic                    erasure_q, erasure_d;
    logic signed [ACC_W-1:0] metric_q, metric_d;

    // Flipping the MSB maps offset binary onto two's complement.
    assign rs       = $signed(rx_sample ^ 8'h80);
    assign cs       = $signed(ref_sample ^ 8'h80);
    assign prod     = rs * cs;
    assign prod_ext = ACC_W'(prod);
    assign sum      = acc_q + prod_ext;

    // One extra bit keeps the magnitude of the most negative sum representable.
    assign sum_ext  = {sum[ACC_W-1], sum};
    assign mag      = sum[ACC_W-1] ? -sum_ext : sum_ext;

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        d_prev_d   = d_prev_q;
        m_code_d   = m_code_q;
        abs_code_d = abs_code_q;
        valid_d    = 1'b0;
        erasure_d  = erasure_q;
        metric_d   = metric_q;
        if (sample_en) begin
            if (sym_sync) begin
                acc_d = prod_ext;
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_W'(SPS - 1)) begin
                abs_code_d = sum[ACC_W-1];
                m_code_d   = sum[ACC_W-1] ^ d_prev_q;
                d_prev_d   = sum[ACC_W-1];
                metric_d   = sum;
                erasure_d  = (mag < (ACC_W+1)'(THRESH));
                valid_d    = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            d_prev_q   <= 1'b0;
            m_code_q   <= 1'b0;
            abs_code_q <= 1'b0;
            valid_q    <= 1'b0;
            erasure_q  <= 1'b0;
            metric_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            d_prev_q   <= d_prev_d;
            m_code_q   <= m_code_d;
            abs_code_q <= abs_code_d;
            valid_q    <= valid_d;
            erasure_q  <= erasure_d;
            metric_q   <= metric_d;
        end
    end

    assign m_code_out   = m_code_q;
    assign abs_code_out = abs_code_q;
    assign code_valid   = valid_q;
    assign erasure      = erasure_q;
    assign sym_metric   = metric_q;
endmodule

// File: tb/tb_dpsk_decode.sv
// Directed bench for dpsk_decode (SPS=16, THRESH=1024) using a 16-point sine reference.
module tb_dpsk_decode;
    logic               clk = 1'b0;
    logic               reset_n;
    logic               sample_en;
    logic               sym_sync;
    logic [7:0]         rx_sample;
    logic [7:0]         ref_sample;
    logic               m_code_out;
    logic               abs_code_out;
    logic               code_valid;
    logic               erasure;
    logic signed [19:0] sym_metric;

    int n_cmp = 0;
    int n_err = 0;

    // Full-correlation metric of one symbol: sum of (ref-128)^2 over the sine table.
    localparam int FULL = 129018;

    dpsk_decode #(.SPS(16), .THRESH(1024)) dut (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .sym_sync(sym_sync),
        .rx_sample(rx_sample), .ref_sample(ref_sample), .m_code_out(m_code_out),
        .abs_code_out(abs_code_out), .code_valid(code_valid), .erasure(erasure),
        .sym_metric(sym_metric)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sine_at(input int k);
        case (k % 16)
            0: return 8'd128;   1: return 8'd177;   2: return 8'd218;   3: return 8'd245;
            4: return 8'd255;   5: return 8'd245;   6: return 8'd218;   7: return 8'd177;
            8: return 8'd128;   9: return 8'd79;    10: return 8'd38;   11: return 8'd11;
            12: return 8'd1;    13: return 8'd11;   14: return 8'd38;   default: return 8'd79;
        endcase
    endfunction

    task automatic step(input logic [7:0] rx, input logic [7:0] rf, input logic sy, input logic en);
        rx_sample  = rx;
        ref_sample = rf;
        sym_sync   = sy;
        sample_en  = en;
        @(posedge clk);
        #1;
    endtask

    // Sends n modulated samples; counts code_valid pulses on every sample except the 16th.
    task automatic send_sym(input logic abs_bit, input logic sync_first, input int n, output int early);
        logic [7:0] rf;
        early = 0;
        for (int k = 0; k < n; k++) begin
            rf = sine_at(k);
            step(abs_bit ? 8'(9'd256 - {1'b0, rf}) : rf, rf, sync_first && (k == 0), 1'b1);
            if (k != 15 && code_valid) early++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(8'd128, 8'd128, 1'b0, 1'b0);
        n_cmp++;
        if ({m_code_out, abs_code_out, code_valid, erasure, sym_metric} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_state: got m=%b abs=%b v=%b er=%b metric=%0d, need all 0",
                     m_code_out, abs_code_out, code_valid, erasure, sym_metric);
        end
        reset_n = 1'b1;
        step(8'd128, 8'd128, 1'b0, 1'b0);
    endtask

    task automatic test_basic_decode();
        logic abs_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic m_seq   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int early;
        for (int s = 0; s < 4; s++) begin
            send_sym(abs_seq[s], s == 0, 16, early);
            n_cmp++;
            if (early !== 0 || code_valid !== 1'b1) begin
                n_err++;
                $display("FAIL basic_valid sym%0d: early=%0d valid=%b, need early=0 valid=1", s, early, code_valid);
            end
            n_cmp++;
            if (abs_code_out !== abs_seq[s] || m_code_out !== m_seq[s] || erasure !== 1'b0 ||
                sym_metric !== (abs_seq[s] ? -FULL : FULL)) begin
                n_err++;
                $display("FAIL basic_code sym%0d: abs=%b m=%b er=%b metric=%0d, need abs=%b m=%b er=0 metric=%0d",
                         s, abs_code_out, m_code_out, erasure, sym_metric, abs_seq[s], m_seq[s],
                         abs_seq[s] ? -FULL : FULL);
            end
        end
        step(8'd128, 8'd128, 1'b0, 1'b0);
        n_cmp++;
        if (code_valid !== 1'b0 || abs_code_out !== 1'b0 || m_code_out !== 1'b1 || sym_metric !== FULL) begin
            n_err++;
            $display("FAIL basic_hold: v=%b abs=%b m=%b metric=%0d, need v=0 abs=0 m=1 metric=%0d",
                     code_valid, abs_code_out, m_code_out, sym_metric, FULL);
        end
    endtask

    task automatic test_zero_signal();
        int early = 0;
        for (int k = 0; k < 16; k++) begin
            step(8'd128, sine_at(k), 1'b0, 1'b1);
            if (k != 15 && code_valid) early++;
        end
        n_cmp++;
        if (early !== 0 || code_valid !== 1'b1 || sym_metric !== 20'sd0 || abs_code_out !== 1'b0 ||
            erasure !== 1'b1 || m_code_out !== 1'b0) begin
            n_err++;
            $display("FAIL zero_signal: early=%0d v=%b metric=%0d abs=%b er=%b m=%b, need 0 1 0 0 1 0",
                     early, code_valid, sym_metric, abs_code_out, erasure, m_code_out);
        end
    endtask

    task automatic test_gapped_enable();
        int early = 0;
        logic [7:0] rf;
        for (int k = 0; k < 16; k++) begin
            rf = sine_at(k);
            step(8'(9'd256 - {1'b0, rf}), rf, 1'b0, 1'b1);
            if (k != 15 && code_valid) early++;
            if (k == 15) break;
            // Junk and a sync pulse on disabled cycles must be ignored.
            step(8'd0, 8'd255, 1'b1, 1'b0);
            if (code_valid) early++;
        end
        n_cmp++;
        if (early !== 0 || code_valid !== 1'b1 || sym_metric !== -FULL || abs_code_out !== 1'b1 ||
            m_code_out !== 1'b1) begin
            n_err++;
            $display("FAIL gapped_enable: early=%0d v=%b metric=%0d abs=%b m=%b, need 0 1 %0d 1 1",
                     early, code_valid, sym_metric, abs_code_out, m_code_out, -FULL);
        end
        step(8'd128, 8'd128, 1'b0, 1'b0);
        n_cmp++;
        if (code_valid !== 1'b0) begin
            n_err++;
            $display("FAIL gapped_pulse_width: valid=%b, need 0", code_valid);
        end
    endtask

    task automatic test_resync();
        int early_a, early_b;
        send_sym(1'b0, 1'b0, 7, early_a);
        send_sym(1'b1, 1'b1, 16, early_b);
        n_cmp++;
        if (early_a + early_b !== 0 || code_valid !== 1'b1) begin
            n_err++;
            $display("FAIL resync_timing: early=%0d valid=%b, need 0 and 1", early_a + early_b, code_valid);
        end
        n_cmp++;
        if (sym_metric !== -FULL || abs_code_out !== 1'b1 || m_code_out !== 1'b0) begin
            n_err++;
            $display("FAIL resync_code: metric=%0d abs=%b m=%b, need %0d 1 0",
                     sym_metric, abs_code_out, m_code_out, -FULL);
        end
    endtask

    task automatic test_extreme();
        int early = 0;
        for (int k = 0; k < 16; k++) begin
            step(8'd0, 8'd255, 1'b0, 1'b1);
            if (k != 15 && code_valid) early++;
        end
        n_cmp++;
        if (early !== 0 || code_valid !== 1'b1 || sym_metric !== -20'sd260096 || abs_code_out !== 1'b1 ||
            m_code_out !== 1'b0 || erasure !== 1'b0) begin
            n_err++;
            $display("FAIL extreme: early=%0d v=%b metric=%0d abs=%b m=%b er=%b, need 0 1 -260096 1 0 0",
                     early, code_valid, sym_metric, abs_code_out, m_code_out, erasure);
        end
    endtask

    // One non-zero product (1023 or 1024) then silence, straddling the erasure threshold.
    task automatic test_thresh();
        logic [7:0] rx_v [2] = '{8'd159, 8'd160};
        logic [7:0] rf_v [2] = '{8'd161, 8'd160};
        logic       er_v [2] = '{1'b1, 1'b0};
        int         mt_v [2] = '{1023, 1024};
        for (int t = 0; t < 2; t++) begin
            step(rx_v[t], rf_v[t], 1'b0, 1'b1);
            for (int k = 1; k < 16; k++) step(8'd128, 8'd200, 1'b0, 1'b1);
            n_cmp++;
            if (code_valid !== 1'b1 || sym_metric !== 20'(mt_v[t]) || erasure !== er_v[t] ||
                abs_code_out !== 1'b0) begin
                n_err++;
                $display("FAIL thresh_%0d: v=%b metric=%0d er=%b abs=%b, need 1 %0d %b 0",
                         mt_v[t], code_valid, sym_metric, erasure, abs_code_out, mt_v[t], er_v[t]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int early;
        send_sym(1'b1, 1'b0, 16, early);
        send_sym(1'b0, 1'b0, 9, early);
        n_cmp++;
        if (abs_code_out !== 1'b1 || sym_metric !== -FULL) begin
            n_err++;
            $display("FAIL reset_mid_pre: abs=%b metric=%0d, need 1 %0d", abs_code_out, sym_metric, -FULL);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_code_out, abs_code_out, code_valid, erasure, sym_metric} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_mid_async: m=%b abs=%b v=%b er=%b metric=%0d, need all 0",
                     m_code_out, abs_code_out, code_valid, erasure, sym_metric);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        n_cmp++;
        if (code_valid !== 1'b0 || sym_metric !== 20'sd0) begin
            n_err++;
            $display("FAIL reset_mid_hold: v=%b metric=%0d, need 0 0", code_valid, sym_metric);
        end
        send_sym(1'b1, 1'b0, 16, early);
        n_cmp++;
        if (early !== 0 || code_valid !== 1'b1 || abs_code_out !== 1'b1 || m_code_out !== 1'b1 ||
            sym_metric !== -FULL) begin
            n_err++;
            $display("FAIL reset_mid_decode: early=%0d v=%b abs=%b m=%b metric=%0d, need 0 1 1 1 %0d",
                     early, code_valid, abs_code_out, m_code_out, sym_metric, -FULL);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        sample_en  = 1'b0;
        sym_sync   = 1'b0;
        rx_sample  = 8'd128;
        ref_sample = 8'd128;
        #1;
        test_reset();
        test_basic_decode();
        test_zero_signal();
        test_gapped_enable();
        test_resync();
        test_extreme();
        test_thresh();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, need completion");
        $fatal(1, "timeout");
    end
endmodule
